// File: rtl/mux_nx1_rr.sv
// N-input, WIDTH-bit registered mux with valid/ready on every channel.
// Channel choice is either an external select or a fair round-robin scan.
module mux_nx1_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 8,
  parameter int SELW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                     state_q;
  logic [SELW-1:0]            rr_ptr_q;
  logic [WIDTH-1:0]           out_q;
  logic [SELW-1:0]            out_sel_q;
  logic [N-1:0][WIDTH-1:0]    din;

  logic            slot_free;
  logic            man_hit, rr_hit, gnt, xfer;
  logic [SELW-1:0] rr_g, g, rr_ptr_d;
  logic [SELW:0]   idx;

  assign din       = in_data;
  assign out_valid = (state_q == FULL);
  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign slot_free = !out_valid || out_ready;

  assign man_hit = ({1'b0, sel} < (SELW+1)'(N)) && in_valid[sel];

  // Scan rr_ptr, rr_ptr+1, ... wrapping at N; first requester wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr_q} + (SELW+1)'(i);
      if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
      if (!rr_hit && in_valid[idx[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_g   = idx[SELW-1:0];
      end
    end
  end

  assign g    = mode ? rr_g : sel;
  assign gnt  = mode ? rr_hit : man_hit;
  assign xfer = !reset && enable && slot_free && gnt;

  assign rr_ptr_d = (g == SELW'(N-1)) ? '0 : g + 1'b1;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      out_q     <= '0;
      out_sel_q <= '0;
    end else if (xfer) begin
      state_q   <= FULL;
      out_q     <= din[g];
      out_sel_q <= g;
      if (mode) rr_ptr_q <= rr_ptr_d;
    end else if (out_ready) begin
      state_q <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: manual select, round-robin scan,
// backpressure, enable gating, out-of-range select and async reset.
module tb_mux_nx1_rr;
  localparam int W = 4, N = 8, SW = 4;

  logic            clk, reset, enable, mode, out_ready, out_valid;
  logic [SW-1:0]   sel, out_sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic [W-1:0]    out;

  int n_chk = 0, n_fail = 0;

  mux_nx1_rr #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k);
  endtask

  initial begin
    int exp_seq[10];
    reset = 1'b1; enable = 1'b1; mode = 1'b0; sel = '0;
    in_data = '0; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_sel", 32'(out_sel), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: manual select of channel 5
    load_data();
    in_data[5*W +: W] = 4'hA;
    sel = 4'd5;
    #1;
    chk("man_rdy", 32'(in_ready), 32'h20);
    step();
    chk("man_out", 32'(out), 32'hA);
    chk("man_sel", 32'(out_sel), 5);
    chk("man_vld", 32'(out_valid), 1);

    // 2: round-robin over all channels, pointer still 0
    load_data();
    mode = 1'b1;
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rr_out", 32'(out), 32'(exp_seq[i]));
      chk("rr_vld", 32'(out_valid), 1);
    end

    // 3: pointer now 2; capture ch2 to leave it at 3, then sparse 7/2
    in_valid = 8'h04;
    step();
    chk("sp_pre", 32'(out), 2);
    in_valid = 8'b1000_0100;
    #1;
    chk("sp_rdy", 32'(in_ready), 32'h80);
    step(); chk("sp_s0", 32'(out_sel), 7); chk("sp_o0", 32'(out), 7);
    step(); chk("sp_s1", 32'(out_sel), 2);
    step(); chk("sp_s2", 32'(out_sel), 7);

    // 4: backpressure with word 7 held, pointer 0
    in_valid = 8'hFF;
    out_ready = 1'b0;
    #1;
    chk("bp_rdy0", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out", 32'(out), 7);
      chk("bp_sel", 32'(out_sel), 7);
      chk("bp_vld", 32'(out_valid), 1);
      chk("bp_rdy", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'h01);
    step();
    chk("bp_rel_out", 32'(out), 0);
    chk("bp_rel_vld", 32'(out_valid), 1);

    // 5: enable low drains the slot, pointer holds at 1
    enable = 1'b0;
    #1;
    chk("en_rdy", 32'(in_ready), 0);
    step();
    chk("en_vld", 32'(out_valid), 0);
    chk("en_sel", 32'(out_sel), 0);
    enable = 1'b1;
    #1;
    chk("en_ptr", 32'(in_ready), 32'h02);
    mode = 1'b0; sel = 4'd9;
    #1;
    chk("sel9_rdy", 32'(in_ready), 0);
    step();
    chk("sel9_vld", 32'(out_valid), 0);

    // 6: async reset between edges while a word is pending
    mode = 1'b1;
    step();
    chk("pre_rst_out", 32'(out), 1);
    chk("pre_rst_vld", 32'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_out", 32'(out), 0);
    chk("ar_vld", 32'(out_valid), 0);
    chk("ar_sel", 32'(out_sel), 0);
    chk("ar_rdy", 32'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    in_data[0 +: W] = 4'hF;
    #1;
    chk("ar_rel_rdy", 32'(in_ready), 32'h01);
    step();
    chk("ar_rel_out", 32'(out), 32'hF);
    chk("ar_rel_sel", 32'(out_sel), 0);
    step();
    chk("ar_next_sel", 32'(out_sel), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
